// File: rtl/clockmanager_rstseq.sv
// clockmanager_rstseq: lock filter, staggered reset release, CPU hold, clock enables.
// Optional define OPTIMSOC_RSTSEQ_RELOCK_EN: lock loss restarts the whole sequence.
module clockmanager_rstseq #(
  parameter int NUM_DOMAINS = 4,
  parameter int RST_WIDTH   = 128,
  parameter int LOCK_FILTER = 16,
  parameter int STAGGER     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_DOMAINS-1:0] locked,
  input  logic [NUM_DOMAINS-1:0] halt_mask,
  input  logic                   sys_halt,
  input  logic                   cpu_reset,
  input  logic                   cpu_start,
  output logic [NUM_DOMAINS-1:0] clk_en,
  output logic                   rst_sys,
  output logic [NUM_DOMAINS-1:0] rst_dom,
  output logic                   rst_cpu,
  output logic                   all_locked,
  output logic                   lock_lost,
  output logic                   sys_is_halted
);

  localparam int MX1 = (LOCK_FILTER > RST_WIDTH) ? LOCK_FILTER : RST_WIDTH;
  localparam int MX  = (MX1 > STAGGER) ? MX1 : STAGGER;
  localparam int CW  = $clog2(MX) + 1;
  localparam int IW  = $clog2(NUM_DOMAINS + 1);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_FILTER,
    ST_PULSE,
    ST_STAGGER,
    ST_RUN
  } state_t;

  state_t                 state_q, state_n;
  logic [CW-1:0]          cnt_q, cnt_n;
  logic [IW-1:0]          idx_q, idx_n;
  logic [CW-1:0]          ccnt_q, ccnt_n;
  logic                   hold_q, hold_n;
  logic                   rst_sys_n, rst_cpu_n, al_n, lost_n, halted_n;
  logic [NUM_DOMAINS-1:0] rst_dom_n, en_n;
  logic                   all_lk, relock;

  assign all_lk = &locked;

`ifdef OPTIMSOC_RSTSEQ_RELOCK_EN
  assign relock = ~all_lk & ((state_q == ST_PULSE) |
                             (state_q == ST_STAGGER) |
                             (state_q == ST_RUN));
`else
  assign relock = 1'b0;
`endif

  // Sequencer next state: lock filter, reset pulse, staggered release.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    idx_n     = idx_q;
    rst_sys_n = rst_sys;
    rst_dom_n = rst_dom;
    al_n      = all_locked;
    unique case (state_q)
      ST_WAIT: begin
        if (all_lk) begin
          state_n = ST_FILTER;
          cnt_n   = '0;
        end
      end
      ST_FILTER: begin
        if (!all_lk) begin
          state_n = ST_WAIT;
          cnt_n   = '0;
        end else if (cnt_q == CW'(LOCK_FILTER - 1)) begin
          state_n = ST_PULSE;
          al_n    = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == CW'(RST_WIDTH - 1)) begin
          rst_sys_n    = 1'b0;
          rst_dom_n[0] = 1'b0;
          cnt_n        = '0;
          idx_n        = IW'(1);
          state_n      = (NUM_DOMAINS == 1) ? ST_RUN : ST_STAGGER;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      ST_STAGGER: begin
        if (cnt_q == CW'(STAGGER - 1)) begin
          for (int i = 0; i < NUM_DOMAINS; i++)
            if (idx_q == IW'(i)) rst_dom_n[i] = 1'b0;
          cnt_n = '0;
          if (idx_q == IW'(NUM_DOMAINS - 1)) state_n = ST_RUN;
          else idx_n = idx_q + IW'(1);
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      ST_RUN: ;
      default: state_n = ST_WAIT;
    endcase
    if (relock) begin
      state_n   = ST_WAIT;
      cnt_n     = '0;
      idx_n     = '0;
      al_n      = 1'b0;
      rst_sys_n = 1'b1;
      rst_dom_n = '1;
    end
  end

  // CPU hold flag and post-start release countdown.
  always_comb begin
    hold_n = hold_q;
    ccnt_n = ccnt_q;
    if (cpu_reset || relock) begin
      hold_n = 1'b1;
      ccnt_n = '0;
    end else if (hold_q) begin
      if (cpu_start && state_q == ST_RUN) begin
        hold_n = 1'b0;
        ccnt_n = '0;
      end
    end else if (ccnt_q != CW'(RST_WIDTH)) begin
      ccnt_n = ccnt_q + CW'(1);
    end
    rst_cpu_n = hold_n | (state_n != ST_RUN) |
                (ccnt_n != CW'(RST_WIDTH));
  end

  // Enables, halt status and sticky lock loss.
  always_comb begin
    en_n     = locked & {NUM_DOMAINS{all_locked}} &
               ~({NUM_DOMAINS{sys_halt}} & halt_mask);
    halted_n = |(halt_mask & ~en_n);
    lost_n   = lock_lost | (all_locked & ~all_lk);
  end

  // Register all state and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT;
      cnt_q         <= '0;
      idx_q         <= '0;
      ccnt_q        <= '0;
      hold_q        <= 1'b1;
      rst_sys       <= 1'b1;
      rst_dom       <= '1;
      rst_cpu       <= 1'b1;
      all_locked    <= 1'b0;
      lock_lost     <= 1'b0;
      clk_en        <= '0;
      sys_is_halted <= 1'b1;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      idx_q         <= idx_n;
      ccnt_q        <= ccnt_n;
      hold_q        <= hold_n;
      rst_sys       <= rst_sys_n;
      rst_dom       <= rst_dom_n;
      rst_cpu       <= rst_cpu_n;
      all_locked    <= al_n;
      lock_lost     <= lost_n;
      clk_en        <= en_n;
      sys_is_halted <= halted_n;
    end
  end

endmodule
